// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
//   Operand stage in front of the datapath ALU. Holds an 8 x 16 register file,
//   the A/B operand registers, a 1-bit B-path shifter and the asel/bsel source
//   muxes. One request is accepted at a time. Rn is read in the first cycle and
//   Rm in the second, both through a single read port. The stage then presents
//   Ain/Bin/ALUop with a valid/ready handshake.
//
// Ports
//   clk, reset             rising-edge clock, synchronous active-high reset
//   req_valid / req_ready  request handshake (ready only while idle)
//   rn, rm                 A / B operand register addresses
//   shift                  B shift: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
//   alu_op                 opcode passed through to ALUop
//   asel                   force Ain to zero
//   bsel                   take Bin from imm (unshifted)
//   imm                    sign-extended immediate
//   wb_en/wb_addr/wb_data  register-file write port (from the C register)
//   Ain, Bin, ALUop        registered operands for the ALU
//   out_valid / out_ready  operand handshake towards the ALU
// -----------------------------------------------------------------------------
module operand_fetch #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] rn,
    input  logic [ADDR_W-1:0] rm,
    input  logic [1:0]        shift,
    input  logic [1:0]        alu_op,
    input  logic              asel,
    input  logic              bsel,
    input  logic [DATA_W-1:0] imm,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] Ain,
    output logic [DATA_W-1:0] Bin,
    output logic [1:0]        ALUop,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_A  = 2'd1,
        RD_B  = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Captured request fields
    logic [ADDR_W-1:0] rn_reg, rm_reg;
    logic [1:0]        shift_reg, alu_op_reg;
    logic              asel_reg, bsel_reg;
    logic [DATA_W-1:0] imm_reg;

    // Operand outputs
    logic [DATA_W-1:0] a_reg, b_reg;
    logic [1:0]        alu_op_out_reg;
    logic              out_valid_reg;

    // Register file: one word register per entry, exposed as a read array
    logic [DATA_W-1:0] rf_word [NREGS];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_rf
            logic [DATA_W-1:0] word_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    word_reg <= '0;
                end else if (wb_en && (wb_addr == ADDR_W'(gi))) begin
                    word_reg <= wb_data;
                end
            end
            assign rf_word[gi] = word_reg;
        end
    endgenerate

    // Single read port: Rn while in RD_A, Rm while in RD_B. A write to the
    // address being read in the same cycle is forwarded (write-first).
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] shifted_data;

    always_comb begin
        read_addr = (state_reg == RD_B) ? rm_reg : rn_reg;
        read_data = rf_word[read_addr];
        if (wb_en && (wb_addr == read_addr)) begin
            read_data = wb_data;
        end
    end

    always_comb begin
        shifted_data = read_data;
        case (shift_reg)
            2'b01:   shifted_data = {read_data[DATA_W-2:0], 1'b0};
            2'b10:   shifted_data = {1'b0, read_data[DATA_W-1:1]};
            2'b11:   shifted_data = {read_data[DATA_W-1], read_data[DATA_W-1:1]};
            default: shifted_data = read_data;
        endcase
    end

    // Next-state and handshake logic
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = RD_A;
                end
            end
            RD_A:  state_next = RD_B;
            RD_B:  state_next = ISSUE;
            ISSUE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            rn_reg         <= '0;
            rm_reg         <= '0;
            shift_reg      <= '0;
            alu_op_reg     <= '0;
            asel_reg       <= 1'b0;
            bsel_reg       <= 1'b0;
            imm_reg        <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            alu_op_out_reg <= '0;
            out_valid_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        rn_reg     <= rn;
                        rm_reg     <= rm;
                        shift_reg  <= shift;
                        alu_op_reg <= alu_op;
                        asel_reg   <= asel;
                        bsel_reg   <= bsel;
                        imm_reg    <= imm;
                    end
                end
                RD_A: begin
                    a_reg <= asel_reg ? '0 : read_data;
                end
                RD_B: begin
                    // The immediate bypasses the shifter entirely
                    b_reg          <= bsel_reg ? imm_reg : shifted_data;
                    alu_op_out_reg <= alu_op_reg;
                    out_valid_reg  <= 1'b1;
                end
                ISSUE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Ain       = a_reg;
    assign Bin       = b_reg;
    assign ALUop     = alu_op_out_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  rn, rm;
    logic [1:0]  shift, alu_op;
    logic        asel, bsel;
    logic [15:0] imm;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [15:0] Ain, Bin;
    logic [1:0]  ALUop;
    logic        out_valid;
    logic        out_ready;

    int tests = 0;
    int fails = 0;

    operand_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rn        (rn),
        .rm        (rm),
        .shift     (shift),
        .alu_op    (alu_op),
        .asel      (asel),
        .bsel      (bsel),
        .imm       (imm),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .Ain       (Ain),
        .Bin       (Bin),
        .ALUop     (ALUop),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [2:0]  rn;
        logic [2:0]  rm;
        logic [1:0]  sh;
        logic [1:0]  op;
        logic        asel;
        logic        bsel;
        logic [15:0] imm;
        logic [15:0] ea;
        logic [15:0] eb;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_reg(input logic [2:0] addr, input logic [15:0] data);
        wb_en   = 1'b1;
        wb_addr = addr;
        wb_data = data;
        tick();
        wb_en   = 1'b0;
    endtask

    // Accept a request, push the expectation, wait for out_valid and compare.
    // Leaves the DUT in ISSUE with out_ready low.
    task automatic issue_req(input logic [2:0] rn_i, input logic [2:0] rm_i,
                             input logic [1:0] sh_i, input logic [1:0] op_i,
                             input logic as_i, input logic bs_i,
                             input logic [15:0] imm_i,
                             input logic [15:0] ea, input logic [15:0] eb);
        int   cnt;
        exp_t e;
        out_ready = 1'b0;
        rn = rn_i; rm = rm_i; shift = sh_i; alu_op = op_i;
        asel = as_i; bsel = bs_i; imm = imm_i;
        req_valid = 1'b1;
        check("req_ready_idle", req_ready, 1);
        sb.push_back('{a: ea, b: eb, op: op_i});
        tick();
        req_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 10) begin
            tick();
            cnt++;
        end
        if (!out_valid) begin
            check("out_valid_timeout", out_valid, 1);
        end else begin
            check("latency", cnt, 2);
            if (sb.size() == 0) begin
                check("scoreboard_empty", 0, 1);
            end else begin
                e = sb.pop_front();
                check("Ain", Ain, e.a);
                check("Bin", Bin, e.b);
                check("ALUop", ALUop, e.op);
            end
        end
        $display("[TB] req rn=%0d rm=%0d sh=%0d op=%0d asel=%0d bsel=%0d imm=%h -> Ain=%h Bin=%h ALUop=%0d",
                 rn_i, rm_i, sh_i, op_i, as_i, bs_i, imm_i, Ain, Bin, ALUop);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_req_ready", req_ready, 1);
    endtask

    initial begin
        // R1=13, R2=6, R3=0x8004 written before these vectors run
        vecs[0] = '{rn: 3'd1, rm: 3'd2, sh: 2'b00, op: 2'b00, asel: 1'b0, bsel: 1'b0, imm: 16'h0000, ea: 16'h000D, eb: 16'h0006};
        vecs[1] = '{rn: 3'd3, rm: 3'd3, sh: 2'b01, op: 2'b01, asel: 1'b0, bsel: 1'b0, imm: 16'h0000, ea: 16'h8004, eb: 16'h0008};
        vecs[2] = '{rn: 3'd2, rm: 3'd3, sh: 2'b10, op: 2'b10, asel: 1'b0, bsel: 1'b0, imm: 16'h0000, ea: 16'h0006, eb: 16'h4002};
        vecs[3] = '{rn: 3'd1, rm: 3'd3, sh: 2'b11, op: 2'b11, asel: 1'b0, bsel: 1'b0, imm: 16'h0000, ea: 16'h000D, eb: 16'hC002};
        vecs[4] = '{rn: 3'd1, rm: 3'd2, sh: 2'b01, op: 2'b00, asel: 1'b1, bsel: 1'b1, imm: 16'hFFFF, ea: 16'h0000, eb: 16'hFFFF};
        vecs[5] = '{rn: 3'd0, rm: 3'd1, sh: 2'b01, op: 2'b01, asel: 1'b0, bsel: 1'b0, imm: 16'h0000, ea: 16'h0000, eb: 16'h001A};
        vecs[6] = '{rn: 3'd2, rm: 3'd2, sh: 2'b11, op: 2'b10, asel: 1'b0, bsel: 1'b0, imm: 16'h1234, ea: 16'h0006, eb: 16'h0003};

        reset = 1'b1; req_valid = 1'b0; rn = '0; rm = '0; shift = '0; alu_op = '0;
        asel = 1'b0; bsel = 1'b0; imm = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        out_ready = 1'b0;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        check("rst_req_ready", req_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_Ain", Ain, 0);
        check("rst_Bin", Bin, 0);
        check("rst_ALUop", ALUop, 0);

        // All registers read back as zero
        for (int i = 0; i < 8; i++) begin
            issue_req(3'(i), 3'(i), 2'b00, 2'b00, 1'b0, 1'b0, 16'h5555, 16'h0000, 16'h0000);
            release_out();
        end

        write_reg(3'd1, 16'd13);
        write_reg(3'd2, 16'd6);
        write_reg(3'd3, 16'h8004);

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            issue_req(vecs[i].rn, vecs[i].rm, vecs[i].sh, vecs[i].op, vecs[i].asel,
                      vecs[i].bsel, vecs[i].imm, vecs[i].ea, vecs[i].eb);
            release_out();
        end

        // Back-pressure: operands held while ISSUE stalls, new requests ignored
        issue_req(3'd1, 3'd3, 2'b10, 2'b01, 1'b0, 1'b0, 16'h0000, 16'h000D, 16'h4002);
        rn = 3'd2; rm = 3'd2; shift = 2'b00; alu_op = 2'b11; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_out_valid", out_valid, 1);
            check("stall_req_ready", req_ready, 0);
            check("stall_Ain", Ain, 16'h000D);
            check("stall_Bin", Bin, 16'h4002);
            check("stall_ALUop", ALUop, 2'b01);
            $display("[TB] stall cycle %0d Ain=%h Bin=%h ALUop=%0d", i, Ain, Bin, ALUop);
        end
        req_valid = 1'b0;
        release_out();
        tick(); tick();
        check("ignored_req_idle", req_ready, 1);
        check("ignored_req_no_valid", out_valid, 0);

        // Write-first forwarding during RD_A and RD_B; a write in ISSUE is not seen
        rn = 3'd1; rm = 3'd2; shift = 2'b00; alu_op = 2'b00; asel = 1'b0; bsel = 1'b0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h00FF;
        tick();
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h0030;
        tick();
        wb_en = 1'b0;
        check("bypass_out_valid", out_valid, 1);
        check("bypass_Ain", Ain, 16'h00FF);
        check("bypass_Bin", Bin, 16'h0030);
        $display("[TB] bypass Ain=%h Bin=%h", Ain, Bin);
        write_reg(3'd1, 16'h1234);
        check("issue_write_Ain", Ain, 16'h00FF);
        check("issue_write_valid", out_valid, 1);
        release_out();
        issue_req(3'd1, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0030);
        release_out();

        // Reset in RD_B with a concurrent write: request dropped, file cleared
        rn = 3'd1; rm = 3'd2; asel = 1'b0; bsel = 1'b0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b1; wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'hAAAA;
        tick();
        reset = 1'b0; wb_en = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_req_ready", req_ready, 1);
        check("midrst_Ain", Ain, 0);
        check("midrst_Bin", Bin, 0);
        $display("[TB] mid-op reset out_valid=%0d req_ready=%0d", out_valid, req_ready);
        for (int i = 0; i < 8; i++) begin
            issue_req(3'(i), 3'(i), 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
            release_out();
        end

        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
